regfile_dump_reader: RTL and testbench

- Sequential read-out engine for the 32x32 register file. It drives one asynchronous read port of the register file and walks an inclusive index range.
- Each register value is snapshotted into a holding register and presented on a valid/ready stream as (index, data) pairs.
- Maintains a running checksum of delivered words.
- Sits beside the datapath as the debug/trace consumer of the register file, the reader end of its read interface.

---
 rtl/regfile_dump_reader.sv | 87 ++++++++
 tb/tb_regfile_dump_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive (wrapping) register-file index range, snapshots each word and
// streams (index, data) pairs out over valid/ready while accumulating a checksum.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_idx,
  input  logic [ADDR_W-1:0] end_idx,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        dbgState
);

  // Stream handshake: a word transfers on any rising edge where out_valid && out_ready;
  // out_valid is only raised in HOLD and only drops after such a transfer (or reset).
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2, DONE = 2'd3} stateT;

  stateT             state;
  logic [ADDR_W-1:0] endIdx;

  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      endIdx       <= '0;
      rf_read_addr <= '0;
      out_index    <= '0;
      out_data     <= '0;
      checksum     <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            endIdx       <= end_idx;
            rf_read_addr <= start_idx;
            checksum     <= '0;
            busy         <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          // Snapshot so later register-file writes cannot disturb the presented word.
          out_data  <= rf_read_data;
          out_index <= rf_read_addr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= checksum + out_data;
            if (out_index == endIdx) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // Index arithmetic wraps naturally at NUM_REGS (a power of two).
              rf_read_addr <= out_index + ADDR_W'(1);
              state        <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register-file array feeds the read port,
// a table of directed dumps plus random dumps are checked against an expected-word queue.
module tb_regfile_dump_reader;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_idx, end_idx, rf_read_addr, out_index;
  logic [DW-1:0] rf_read_data, out_data, checksum;
  logic          out_valid, out_ready, busy, done;
  logic [1:0]    dbgState;

  logic [DW-1:0] rf [NR];
  assign rf_read_data = rf[rf_read_addr];

  regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_idx(start_idx), .end_idx(end_idx),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data), .busy(busy),
    .done(done), .checksum(checksum), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    int            fill;
    bit            randReady;
    int            stallIdx;
    bit            injStart;
    logic [DW-1:0] expSum;
    int            expCycles;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_rf(input int mode);
    for (int i = 0; i < NR; i++)
      rf[i] = (mode == 0) ? DW'(i) * 32'h01010101 : (mode == 1) ? '1 : $urandom;
  endtask

  // Runs one dump; expected words come from the range rules applied to the array model.
  task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e, input bit randReady,
                          input int stallIdx, input bit injStart, input bit haveExp,
                          input logic [DW-1:0] expSum, input int expCycles);
    logic [AW-1:0] d;
    logic [AW-1:0] idx;
    logic [DW-1:0] sum;
    int n, cyc, stallLeft;
    bit seenDone, prevValid, prevHs, stalled, injected;
    d = e - s;
    n = int'(d) + 1;
    exp_q.delete();
    sum = '0;
    for (int k = 0; k < n; k++) begin
      idx = s + AW'(k);
      exp_q.push_back({idx, rf[idx]});
      sum = sum + rf[idx];
    end
    if (haveExp) sum = expSum;

    @(negedge clk);
    check("idle_busy_before_start", busy, 0);
    start = 1'b1; start_idx = s; end_idx = e; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; start_idx = AW'($urandom); end_idx = AW'($urandom);
    cyc = 0; stallLeft = 0; seenDone = 0; prevValid = 0; prevHs = 0; stalled = 0; injected = 0;
    while (cyc < 400) begin
      if (prevValid && !prevHs) check("valid_dropped_without_handshake", out_valid, 1);
      if (done) begin
        seenDone = 1;
        check("done_busy", busy, 1);
        check("done_valid", out_valid, 0);
        check("words_remaining_at_done", exp_q.size(), 0);
        check("checksum_at_done", checksum, sum);
        if (expCycles >= 0) check("cycles_to_done", cyc, expCycles);
        break;
      end
      if (busy && !out_valid) begin
        if (exp_q.size() > 0) check("read_addr", rf_read_addr, exp_q[0][AW+DW-1:DW]);
        else check("read_past_end", 1, 0);
      end
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (out_valid && stallIdx >= 0 && int'(out_index) == stallIdx && !stalled) begin
        stalled = 1;
        stallLeft = 5;
      end
      if (stallLeft > 0) begin
        out_ready = 1'b0;
        rf[stallIdx] = 32'hDEADBEEF;
        check("stall_valid", out_valid, 1);
        if (exp_q.size() > 0) check("stall_data", out_data, exp_q[0][DW-1:0]);
        stallLeft--;
      end
      if (injStart && out_valid && !injected) begin
        start = 1'b1; start_idx = AW'($urandom); end_idx = AW'($urandom);
        injected = 1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check("word_index", out_index, exp_q[0][AW+DW-1:DW]);
          check("word_data", out_data, exp_q[0][DW-1:0]);
          void'(exp_q.pop_front());
        end else check("extra_word", 1, 0);
      end
      prevValid = out_valid;
      prevHs = out_valid && out_ready;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!seenDone) check("done_timeout", 0, 1);
    out_ready = 1'b0;
    @(negedge clk);
    check("after_done_pulse", done, 0);
    check("after_done_busy", busy, 0);
    check("after_done_state", dbgState, 0);
    repeat (3) @(negedge clk);
    check("checksum_held_in_idle", checksum, sum);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{s: 3,  e: 5,  fill: 0, randReady: 0, stallIdx: -1, injStart: 0, expSum: 32'h0C0C0C0C, expCycles: 6};
    vecs[1] = '{s: 30, e: 1,  fill: 0, randReady: 0, stallIdx: -1, injStart: 0, expSum: 32'h3E3E3E3E, expCycles: 8};
    vecs[2] = '{s: 3,  e: 5,  fill: 0, randReady: 0, stallIdx: 4,  injStart: 0, expSum: 32'h0C0C0C0C, expCycles: 11};
    vecs[3] = '{s: 2,  e: 6,  fill: 0, randReady: 0, stallIdx: -1, injStart: 1, expSum: 32'h14141414, expCycles: 10};
    vecs[4] = '{s: 0,  e: 31, fill: 1, randReady: 0, stallIdx: -1, injStart: 0, expSum: 32'hFFFFFFE0, expCycles: 64};
    vecs[5] = '{s: 7,  e: 7,  fill: 0, randReady: 0, stallIdx: -1, injStart: 0, expSum: 32'h07070707, expCycles: 2};
    vecs[6] = '{s: 0,  e: 31, fill: 0, randReady: 1, stallIdx: -1, injStart: 0, expSum: 32'hF1F1F1F0, expCycles: -1};
    vecs[7] = '{s: 10, e: 9,  fill: 0, randReady: 0, stallIdx: -1, injStart: 0, expSum: 32'hF1F1F1F0, expCycles: 64};

    reset = 1'b1; start = 1'b0; start_idx = '0; end_idx = '0; out_ready = 1'b0;
    fill_rf(0);
    repeat (2) @(negedge clk);
    check("reset_state", dbgState, 0);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_checksum", checksum, 0);
    check("reset_addr", rf_read_addr, 0);
    check("reset_index", out_index, 0);
    check("reset_data", out_data, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill_rf(vecs[v].fill);
      run_dump(vecs[v].s, vecs[v].e, vecs[v].randReady, vecs[v].stallIdx, vecs[v].injStart,
               1'b1, vecs[v].expSum, vecs[v].expCycles);
    end

    for (int r = 0; r < 20; r++) begin
      fill_rf(2);
      run_dump(AW'($urandom), AW'($urandom), 1'b1, -1, 1'($urandom_range(0, 1)), 1'b0, '0, -1);
    end

    // Reset while a word is being presented, then a clean dump afterwards.
    fill_rf(0);
    @(negedge clk);
    start = 1'b1; start_idx = 5'd3; end_idx = 5'd10; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
    check("valid_before_reset", out_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midhold_reset_valid", out_valid, 0);
    check("midhold_reset_busy", busy, 0);
    check("midhold_reset_done", done, 0);
    check("midhold_reset_checksum", checksum, 0);
    check("midhold_reset_state", dbgState, 0);
    reset = 1'b0;
    run_dump(5'd3, 5'd5, 1'b0, -1, 1'b0, 1'b1, 32'h0C0C0C0C, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
